// File: rtl/fft_input_fold_stream_pkg.sv
// Shared types for the FFT input fold stage.
//   complex_product_t : packed complex sample {re, im}, each PROD_W bits signed.
package fft_input_fold_stream_pkg;

  localparam int unsigned PROD_W = 32;

  typedef struct packed {
    logic signed [PROD_W-1:0] re;
    logic signed [PROD_W-1:0] im;
  } complex_product_t;

endpackage

// File: rtl/fft_input_fold_stream_fold_buffer.sv
// Half-frame sample store for the fold stage.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : read data, combinational from raddr
// Contents are deliberately not reset.
module fold_buffer
  import fft_input_fold_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  complex_product_t wdata,
  input  logic [AW-1:0]    raddr,
  output complex_product_t rdata
);

  complex_product_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_input_fold_stream.sv
// Folds a streamed FFT frame into butterfly pairs (x[k], x[k+N/2]).
// The first half of each frame is stored; every second-half sample is
// emitted together with its stored partner one cycle after acceptance.
//   clk, reset            : clock, asynchronous active-low reset
//   log2_n                : requested frame length as log2(N), sampled at frame start
//   in_valid/in_ready     : input handshake; in_sof marks sample 0 of a frame
//   data_in               : input sample
//   data_out_0/data_out_1 : x[k] / x[k+N/2]
//   out_index, out_last   : pair index k, last pair of the frame
//   out_valid/out_ready   : output pair handshake
//   sync_err              : one-cycle pulse when in_sof forces a resynchronisation
module fft_input_fold_stream
  import fft_input_fold_stream_pkg::*;
#(
  parameter int unsigned N_MAX     = 64,
  parameter int unsigned LOG2_NMAX = $clog2(N_MAX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LOG2_NMAX-1:0] log2_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  complex_product_t     data_in,
  output complex_product_t     data_out_0,
  output complex_product_t     data_out_1,
  output logic [LOG2_NMAX-2:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 sync_err
);

  localparam int unsigned CW = LOG2_NMAX;
  localparam int unsigned HW = LOG2_NMAX - 1;

  logic [CW-1:0]    cnt, cnt_eff, cnt_nxt;
  logic [CW-1:0]    lg_q, lg_req, lg_eff;
  logic [CW:0]      half_q, n_eff, half_eff;
  logic             pair_q, pair_eff, last_eff;
  logic             accept, restart;
  logic [HW-1:0]    k_eff;
  complex_product_t rd_data;

  // A restarting in_sof sample is processed as cnt = 0 of a new frame in the
  // same cycle, so length latching and FILL/PAIR decisions use cnt_eff.
  always_comb begin
    lg_req   = (log2_n < CW'(2) || log2_n > CW'(LOG2_NMAX)) ? CW'(LOG2_NMAX) : log2_n;
    half_q   = (CW+1)'(1) << (lg_q - CW'(1));
    pair_q   = {1'b0, cnt} >= half_q;
    in_ready = !pair_q || !out_valid || out_ready;
    accept   = in_valid && in_ready;
    restart  = accept && in_sof && (cnt != '0);
    cnt_eff  = restart ? '0 : cnt;
    lg_eff   = (cnt_eff == '0) ? lg_req : lg_q;
    n_eff    = (CW+1)'(1) << lg_eff;
    half_eff = n_eff >> 1;
    pair_eff = {1'b0, cnt_eff} >= half_eff;
    k_eff    = HW'({1'b0, cnt_eff} - half_eff);
    last_eff = ({1'b0, cnt_eff} == n_eff - (CW+1)'(1));
    cnt_nxt  = last_eff ? '0 : cnt_eff + CW'(1);
  end

  fold_buffer #(
    .DEPTH (N_MAX / 2),
    .AW    (HW)
  ) u_fold_buffer (
    .clk   (clk),
    .we    (accept && !pair_eff),
    .waddr (HW'(cnt_eff)),
    .wdata (data_in),
    .raddr (k_eff),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      lg_q       <= CW'(LOG2_NMAX);
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      sync_err   <= 1'b0;
      out_index  <= '0;
      data_out_0 <= '0;
      data_out_1 <= '0;
    end else begin
      sync_err <= restart;
      if (accept) begin
        cnt  <= cnt_nxt;
        lg_q <= lg_eff;
      end
      if (accept && pair_eff) begin
        out_valid  <= 1'b1;
        data_out_0 <= rd_data;
        data_out_1 <= data_in;
        out_index  <= k_eff;
        out_last   <= last_eff;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_fold_stream.sv
module tb_fft_input_fold_stream;
  import fft_input_fold_stream_pkg::*;

  localparam int N_MAX     = 64;
  localparam int LOG2_NMAX = 6;

  logic                 clk;
  logic                 reset;
  logic [LOG2_NMAX-1:0] log2_n;
  logic                 in_valid, in_ready, in_sof;
  complex_product_t     data_in, data_out_0, data_out_1;
  logic [LOG2_NMAX-2:0] out_index;
  logic                 out_valid, out_ready, out_last, sync_err;

  fft_input_fold_stream #(
    .N_MAX     (N_MAX),
    .LOG2_NMAX (LOG2_NMAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .log2_n     (log2_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .data_in    (data_in),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the samples of the current frame in arrival order, and
  // the pair (if any) that should currently sit on the output.
  complex_product_t m_frame[$];
  int               m_n = N_MAX;
  bit               m_ov, m_last, m_sync;
  complex_product_t m_d0, m_d1;
  int               m_k;
  int               pairs_out = 0;
  int               sync_seen = 0;
  logic             ready_on  = 1'b1;
  int               stall_cycles = 0;

  function automatic complex_product_t mk(input int v);
    complex_product_t c;
    c.re = v;
    c.im = -3 * v;
    return c;
  endfunction

  function automatic int frame_len(input logic [LOG2_NMAX-1:0] lg);
    if (lg < 2 || lg > LOG2_NMAX) return N_MAX;
    return 1 << lg;
  endfunction

  task automatic model_reset();
    m_frame.delete();
    m_ov   = 0;
    m_last = 0;
    m_sync = 0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model by
  // the handshakes that the next rising edge will perform.
  task automatic step(output bit fired);
    bit               exp_rdy, in_fire, out_fire;
    int               idx;
    complex_product_t s;
    if (stall_cycles > 0) begin
      out_ready = 1'b0;
      stall_cycles--;
    end else begin
      out_ready = ready_on;
    end
    @(negedge clk);
    exp_rdy = (m_frame.size() < m_n / 2) || !m_ov || out_ready;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    check("sync_err", sync_err, m_sync);
    if (m_ov) begin
      check("data_out_0", data_out_0, m_d0);
      check("data_out_1", data_out_1, m_d1);
      check("out_index", 64'(out_index), 64'(m_k));
      check("out_last", out_last, m_last);
    end
    if (sync_err) sync_seen++;
    out_fire = m_ov && out_ready;
    in_fire  = in_valid && exp_rdy;
    m_sync   = 0;
    if (out_fire) begin
      pairs_out++;
      m_ov = 0;
    end
    if (in_fire) begin
      s = data_in;
      if (in_sof && m_frame.size() != 0) begin
        m_frame.delete();
        m_sync = 1;
      end
      if (m_frame.size() == 0) m_n = frame_len(log2_n);
      idx = m_frame.size();
      m_frame.push_back(s);
      if (idx >= m_n / 2) begin
        m_ov   = 1;
        m_d0   = m_frame[idx - m_n / 2];
        m_d1   = s;
        m_k    = idx - m_n / 2;
        m_last = (idx == m_n - 1);
      end
      if (m_frame.size() == m_n) m_frame.delete();
    end
    fired = in_fire;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit sof);
    bit f;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    data_in  = mk(v);
    do begin
      step(f);
      guard++;
    end while (!f && guard < 20);
    check("accept_in_time", f, 1'b1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    bit f;
    repeat (n) step(f);
  endtask

  initial begin
    int p0, s0;
    bit f;
    reset    = 1'b0;
    log2_n   = 3;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    data_in  = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_data_out_0", data_out_0, 64'd0);
    check("rst_data_out_1", data_out_1, 64'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;

    // N=8 back-to-back, pair valid one cycle after sample 5
    p0 = pairs_out;
    for (int v = 1; v <= 8; v++) begin
      send(v, 0);
      if (v == 5) check("latency_valid", out_valid, 1'b1);
    end
    idle(2);
    check("n8_pairs", 64'(pairs_out - p0), 64'd4);

    // Output stall at pair k=1 blocks input, pair held
    p0 = pairs_out;
    for (int v = 1; v <= 6; v++) send(10 + v, 0);
    stall_cycles = 3;
    send(17, 0);
    send(18, 0);
    idle(2);
    check("stall_pairs", 64'(pairs_out - p0), 64'd4);

    // Length change mid-frame takes effect on the next frame
    p0 = pairs_out;
    for (int v = 1; v <= 8; v++) begin
      if (v == 6) log2_n = 4;
      send(20 + v, 0);
    end
    for (int v = 1; v <= 16; v++) send(40 + v, 0);
    idle(2);
    check("resize_pairs", 64'(pairs_out - p0), 64'd12);

    // in_sof at cnt=3 restarts the frame
    log2_n = 3;
    p0 = pairs_out;
    s0 = sync_seen;
    for (int v = 1; v <= 3; v++) send(60 + v, 0);
    send(100, 1);
    for (int v = 1; v <= 7; v++) send(100 + v, 0);
    idle(2);
    check("resync_pulses", 64'(sync_seen - s0), 64'd1);
    check("resync_pairs", 64'(pairs_out - p0), 64'd4);

    // Asynchronous reset mid-PAIR
    for (int v = 1; v <= 6; v++) send(200 + v, 0);
    check("pre_rst_valid", out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_last", out_last, 1'b0);
    check("async_rst_data_out_0", data_out_0, 64'd0);
    model_reset();
    m_n = N_MAX;
    step(f);
    reset = 1'b1;
    p0 = pairs_out;
    for (int v = 1; v <= 8; v++) send(v, 0);
    idle(2);
    check("post_rst_pairs", 64'(pairs_out - p0), 64'd4);

    // Illegal log2_n selects N_MAX
    log2_n = 1;
    p0 = pairs_out;
    for (int v = 1; v <= N_MAX; v++) send(300 + v, 0);
    idle(2);
    check("clamp_pairs", 64'(pairs_out - p0), 64'(N_MAX / 2));

    // Randomised traffic, lengths, back-pressure and stray in_sof
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom % 4) != 0;
      in_sof     = ($urandom % 25) == 0;
      data_in.re = $urandom;
      data_in.im = $urandom;
      if (($urandom % 50) == 0) log2_n = LOG2_NMAX'($urandom_range(0, 7));
      ready_on   = ($urandom % 3) != 0;
      step(f);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    ready_on = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
